ad_serial_capture: RTL and testbench
====================================

// Module: ad_serial_capture
// PURPOSE
//  Front end of the A/D Nios path. Drives one serial 12-bit ADC (CS_n/SCLK/SDATA,
//  16-clock frame) and buffers samples in a show-ahead FIFO. The FIFO is read
//  by the Nios Avalon slave logic, whose status/enable bits go through hidden lcells.
//  Conversions start on a single-cycle trigger while capture is enabled.
// PARAMETERS
//  DATA_W      12  ADC result width; the frame LSBs after 16-DATA_W leading zero bits
//  SCLK_DIV    4   clk cycles per SCLK half-period, >=2
//  FIFO_AW     4   FIFO address width; depth = 2**FIFO_AW
// PORTS
//  clk         in   1         system clock; all logic is on its rising edge
//  reset_n     in   1         asynchronous, active-low reset
//  ena         in   1         capture enable; trigger is ignored while low
//  trigger     in   1         one-cycle conversion request
//  adc_cs_n    out  1         ADC chip select, active low
//  adc_sclk    out  1         ADC serial clock; idles high
//  adc_sdata   in   1         ADC serial data, MSB first; pre-synchronised upstream
//  busy        out  1         high from an accepted trigger until the end of GAP
//  rd          in   1         pop FIFO head; ignored while empty
//  rd_data     out  DATA_W    FIFO head word (show-ahead); holds last value when empty
//  fifo_empty  out  1         FIFO holds no words
//  fifo_count  out  FIFO_AW+1 number of words in the FIFO, 0..2**FIFO_AW
//  overrun     out  1         sticky: a sample was dropped because the FIFO was full
//  clr_overrun in   1         one-cycle clear of overrun
// BEHAVIOUR
//  Reset values: adc_cs_n=1, adc_sclk=1, busy=0, rd_data=0, fifo_empty=1,
//   fifo_count=0, overrun=0, FSM in IDLE. All outputs are registered.
//  FSM: IDLE -> START -> SHIFT -> PUSH -> GAP -> IDLE.
//   IDLE:  trigger&&ena latches the request; next cycle START, busy=1.
//   START: adc_cs_n=0, adc_sclk=1; lasts SCLK_DIV cycles.
//   SHIFT: adc_sclk toggles every SCLK_DIV cycles, first edge falling, for 16 periods
//          (32*SCLK_DIV cycles). adc_sdata is sampled into the shift register on
//          the cycle adc_sclk is driven 0->1. Last period ends high.
//   PUSH:  1 cycle. adc_cs_n=1. Writes frame[DATA_W-1:0] to the FIFO.
//   GAP:   SCLK_DIV cycles with adc_cs_n=1 (ADC quiet time). Then IDLE, busy=0.
//  Latency: a trigger accepted in cycle t writes in cycle t+1+33*SCLK_DIV. The word
//   is visible on rd_data/fifo_count one cycle later. Next accept is possible at
//   t+2+34*SCLK_DIV.
//  Trigger outside IDLE is ignored; requests do not queue.
//  ena falling mid-frame: the current frame completes and is pushed normally.
//  FIFO:
//   - rd pops and rd_data advances on the next edge.
//   - rd while empty has no effect.
//   - Push and pop in the same cycle: both happen and count is unchanged. This
//     holds when full; when empty, the pushed word becomes the head.
//   - Push while full without pop: word is dropped, overrun=1, FIFO unchanged.
//   - Pointers wrap modulo 2**FIFO_AW. fifo_count is a separate up/down counter.
//  overrun: set has priority over clr_overrun in the same cycle.
//  reset_n asserted mid-frame: immediate return to reset values. The partial frame
//   is discarded and the FIFO is emptied.
// TESTING (SCLK_DIV=2, DATA_W=12, FIFO_AW=2)
//  1. ADC model returns 0x0A5C, trigger once -> cs_n low for 66 cycles,
//     16 SCLK rising edges, rd_data=0xA5C, fifo_count=1 at t+68.
//  2. Trigger while busy, and trigger with ena=0 -> ignored, no extra frame,
//     fifo_count unchanged.
//  3. Five conversions 0x001..0x005 with no reads -> count=4, overrun=1,
//     reads return 0x001..0x004 in order, then empty=1.
//  4. Full FIFO, rd in the PUSH cycle -> count stays 4, no overrun, new word at tail.
//     Set and clr_overrun in the same cycle -> overrun=1.
//  5. reset_n low during SHIFT bit 7 -> cs_n=1, sclk=1, empty=1 immediately.
//     The next trigger captures a clean frame.
//  6. rd on empty -> count stays 0, rd_data holds the last value.
//     Empty+push+rd same cycle -> count=1.

Source files
------------

// File: rtl/ad_serial_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ad_serial_capture: serial 12-bit ADC frame driver with show-ahead FIFO      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module ad_serial_capture #(
  parameter int DATA_W   = 12,
  parameter int SCLK_DIV = 4,
  parameter int FIFO_AW  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ena,
  input  logic               trigger,
  output logic               adc_cs_n,
  output logic               adc_sclk,
  input  logic               adc_sdata,
  output logic               busy,
  input  logic               rd,
  output logic [DATA_W-1:0]  rd_data,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overrun,
  input  logic               clr_overrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_PUSH  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [4:0]         half_q, half_d;
  logic [DATA_W-1:0]  sr_q, sr_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               busy_q, busy_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               empty_q, empty_d;
  logic               overrun_q, overrun_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               push, do_pop, do_write, drop;
  logic [FIFO_AW-1:0] rd_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      half_q    <= '0;
      sr_q      <= '0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      busy_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      empty_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      half_q    <= half_d;
      sr_q      <= sr_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      empty_q   <= empty_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_ptr_q] <= sr_q;
  end

  // div counts clk cycles within a half-period; half counts SCLK half-periods
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    unique case (state_q)
      S_IDLE: begin
        if (trigger && ena) begin
          state_d = S_START;
          div_d   = '0;
        end
      end
      S_START: begin
        if (div_q == DIV_LAST) begin
          state_d = S_SHIFT;
          div_d   = '0;
          half_d  = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (half_q == 5'd31) state_d = S_PUSH;
          else                 half_d  = half_q + 5'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_PUSH: begin
        state_d = S_GAP;
        div_d   = '0;
      end
      S_GAP: begin
        if (div_q == DIV_LAST) state_d = S_IDLE;
        else                   div_d   = div_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs derive from the next state so they are registered yet cycle-aligned
  always_comb begin
    cs_n_d = !((state_d == S_START) || (state_d == S_SHIFT));
    sclk_d = (state_d == S_SHIFT) ? half_d[0] : 1'b1;
    busy_d = (state_d != S_IDLE);
    sr_d   = (sclk_d && !sclk_q) ? {sr_q[DATA_W-2:0], adc_sdata} : sr_q;
  end

  always_comb begin
    push      = (state_q == S_PUSH);
    do_pop    = rd && !empty_q;
    do_write  = push && ((count_q != FULL_CNT) || do_pop);
    drop      = push && (count_q == FULL_CNT) && !do_pop;
    rd_next   = rd_ptr_q + 1'b1;
    wr_ptr_d  = do_write ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = do_pop ? rd_next : rd_ptr_q;
    count_d   = count_q;
    if (do_write && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_write && do_pop) count_d = count_q - 1'b1;
    // Head comes from the incoming word whenever the FIFO has no other entry
    rd_data_d = rd_data_q;
    if (do_write && ((count_q == '0) || (do_pop && count_q == 1)))
      rd_data_d = sr_q;
    else if (do_pop && count_q > 1)
      rd_data_d = mem_q[rd_next];
    empty_d   = (count_d == '0);
    overrun_d = drop ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
  end

  assign adc_cs_n   = cs_n_q;
  assign adc_sclk   = sclk_q;
  assign busy       = busy_q;
  assign rd_data    = rd_data_q;
  assign fifo_empty = empty_q;
  assign fifo_count = count_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ad_serial_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ad_serial_capture: directed bench with ADC model and FIFO scoreboard     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_ad_serial_capture;

  logic        clk = 1'b0;
  logic        reset_n, ena, trigger, adc_sdata, rd, clr_overrun;
  logic        adc_cs_n, adc_sclk, busy, fifo_empty, overrun;
  logic [11:0] rd_data;
  logic [2:0]  fifo_count;

  logic [15:0] adc_word = '0;
  int          bidx = 15;
  int          cs_low = 0;
  int          sclk_rises = 0;
  logic [11:0] model_q [$];
  logic [11:0] last_word;
  logic        ovr_exp;
  int          vectors = 0;
  int          errors = 0;

  ad_serial_capture #(.DATA_W(12), .SCLK_DIV(2), .FIFO_AW(2)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .trigger(trigger),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_sdata(adc_sdata),
    .busy(busy), .rd(rd), .rd_data(rd_data), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // ADC model: presents the next bit MSB-first on each falling SCLK edge
  always @(negedge adc_cs_n) bidx = 15;
  always @(negedge adc_sclk)
    if (adc_cs_n === 1'b0 && bidx >= 0) begin
      adc_sdata = adc_word[bidx];
      bidx--;
    end
  always @(negedge clk) if (adc_cs_n === 1'b0) cs_low++;
  always @(posedge adc_sclk) if (adc_cs_n === 1'b0) sclk_rises++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_head();
    return (model_q.size() > 0) ? 32'(model_q[0]) : 32'(last_word);
  endfunction

  task automatic check_fifo(input string tag);
    check({tag, "_count"}, 32'(fifo_count), 32'(model_q.size()));
    check({tag, "_empty"}, 32'(fifo_empty), 32'(model_q.size() == 0));
    check({tag, "_head"},  32'(rd_data), exp_head());
  endtask

  // One conversion; caller and task both sit on a falling clk edge
  task automatic conv(input logic [11:0] w, input bit rd_at_push,
                      input bit clr_at_push, input bit extra_trig);
    int   n0;
    logic drop;
    adc_word   = {4'h0, w};
    cs_low     = 0;
    sclk_rises = 0;
    n0         = model_q.size();
    trigger    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trigger = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("cs_fall", 32'(adc_cs_n), 32'd0);
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      trigger = extra_trig && (i == 20);
    end
    check("count_before_push", 32'(fifo_count), 32'(n0));
    rd          = rd_at_push;
    clr_overrun = clr_at_push;
    @(negedge clk);
    rd          = 1'b0;
    clr_overrun = 1'b0;
    drop = (n0 == 4) && !rd_at_push;
    if (rd_at_push && n0 > 0) last_word = model_q.pop_front();
    if (!drop) model_q.push_back(w);
    ovr_exp = drop ? 1'b1 : (clr_at_push ? 1'b0 : ovr_exp);
    check_fifo("push");
    check("overrun", 32'(overrun), 32'(ovr_exp));
    check("cs_after_push", 32'(adc_cs_n), 32'd1);
    @(negedge clk);
    check("busy_gap", 32'(busy), 32'd1);
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    check("cs_low_cycles", 32'(cs_low), 32'd66);
    check("sclk_rises", 32'(sclk_rises), 32'd16);
  endtask

  task automatic idle_check(input string tag);
    cs_low = 0;
    repeat (80) @(negedge clk);
    check({tag, "_no_frame"}, 32'(cs_low), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check_fifo(tag);
  endtask

  task automatic read_one();
    check("head_before_rd", 32'(rd_data), exp_head());
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    last_word = model_q.pop_front();
    check_fifo("read");
  endtask

  task automatic rd_empty();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check_fifo("rd_empty");
  endtask

  initial begin
    reset_n = 1'b0; ena = 1'b1; trigger = 1'b0; adc_sdata = 1'b0;
    rd = 1'b0; clr_overrun = 1'b0;
    last_word = '0; ovr_exp = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check_fifo("rst");
    reset_n = 1'b1;
    @(negedge clk);

    conv(12'hA5C, 1'b0, 1'b0, 1'b0);
    conv(12'h123, 1'b0, 1'b0, 1'b1);
    idle_check("busy_trig");
    ena = 1'b0; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0; ena = 1'b1;
    check("ena_low_busy", 32'(busy), 32'd0);
    idle_check("ena_low");
    read_one();
    read_one();
    rd_empty();

    conv(12'h3C3, 1'b1, 1'b0, 1'b0);
    read_one();

    for (int k = 1; k <= 5; k++) conv(12'(k), 1'b0, 1'b0, 1'b0);
    repeat (4) read_one();
    check("overrun_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    ovr_exp = 1'b0;
    check("overrun_clr", 32'(overrun), 32'd0);

    for (int k = 6; k <= 9; k++) conv(12'(k), 1'b0, 1'b0, 1'b0);
    conv(12'h00A, 1'b1, 1'b0, 1'b0);
    conv(12'h00B, 1'b0, 1'b1, 1'b0);
    repeat (4) read_one();

    conv(12'h5A5, 1'b0, 1'b0, 1'b0);
    adc_word = 16'h0FFF;
    trigger  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    trigger = 1'b0;
    repeat (32) @(negedge clk);
    check("mid_frame_cs", 32'(adc_cs_n), 32'd0);
    reset_n = 1'b0;
    #1;
    model_q.delete();
    last_word = '0;
    ovr_exp   = 1'b0;
    check("arst_cs_n", 32'(adc_cs_n), 32'd1);
    check("arst_sclk", 32'(adc_sclk), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check_fifo("arst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    conv(12'hC3A, 1'b0, 1'b0, 1'b0);
    read_one();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
